ps2_keyboard: RTL and testbench
===============================

Name: ps2_keyboard

Overview:
- Input-direction counterpart to the memory-mapped screen path. Receives PS/2 set-2 scan-code frames from an external keyboard.
- Decodes make/break/extended sequences into Hack keyboard codes.
- Holds the code of the currently pressed key in a register. The top level muxes that register onto the CPU RAM read port at the KBD address.
- Runs entirely in the CLK_50 domain; both PS/2 lines are asynchronous inputs.

Parameters:
FILTER_LEN, 8, consecutive identical synchronized samples required before ps2_clk/ps2_data level changes are accepted
TIMEOUT_CYCLES, 100000, CLK_50 cycles without a ps2_clk falling edge mid-frame before the frame is abandoned (2 ms)
DATA_WIDTH, 16, width of key_code

Ports:
CLK_50  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high; clears all state
ps2_clk  input  1  raw PS/2 clock, asynchronous
ps2_data  input  1  raw PS/2 data, asynchronous
key_code  output  DATA_WIDTH  Hack code of held key, 0 = none
scan_code  output  8  last correctly received byte
scan_valid  output  1  one-cycle pulse when scan_code updates
parity_err  output  1  one-cycle pulse on odd-parity failure
frame_err  output  1  one-cycle pulse on bad stop bit or timeout

Behaviour:
- Reset (synchronous, active-high):
  - All outputs are 0; receiver goes to IDLE.
  - ext_flag, brk_flag, shift and held_scan are cleared.
  - Filtered line levels are set to 1.
- Input conditioning:
  - Each line passes through a 2-FF synchronizer, then a filter counter; the filtered level flips only after FILTER_LEN equal samples.
  - A falling edge is filtered ps2_clk going 1->0. It is a one-cycle strobe `fall`.
- Receiver FSM, sampling filtered ps2_data on `fall`:
  - IDLE: on `fall` with data=0 (start bit) -> DATA, bit count 0. A start bit of 1 is ignored; stay in IDLE.
  - DATA: shift in LSB first; after the 8th bit -> PARITY.
  - PARITY: capture the bit -> STOP.
  - STOP: on `fall`:
    - data=1 and odd parity over 8 data bits + parity bit: scan_code <= byte, scan_valid pulses the next cycle.
    - parity bad: parity_err pulses, byte discarded.
    - stop=0: frame_err pulses (takes priority over parity_err), byte discarded.
    - Every case returns to IDLE.
  - Timeout: a watchdog counter resets on each `fall`. If it reaches TIMEOUT_CYCLES in any state other than IDLE: frame_err pulses, state -> IDLE, partial byte discarded.
- Decoder, acting on the cycle scan_valid is high:
  - 0xE0: ext_flag <= 1.
  - 0xF0: brk_flag <= 1.
  - Any other byte: decode (byte, ext_flag, brk_flag), then clear both flags.
  - Shift (non-ext 0x12, 0x59): make sets shift, break clears it; key_code unchanged.
  - Mapped make: key_code <= code and held_scan <= {ext, byte}, one cycle after scan_valid.
  - Break whose {ext, byte} equals held_scan: key_code <= 0 and held_scan cleared.
  - Break of any other key: no change.
  - Unmapped make: no change.
  - Typematic repeat of the held key re-writes the same value.
- Code map, non-extended:
  - Letters A..Z are 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A. They give 97+i, or 65+i when shift is held.
  - Digits 0..9 are 45 16 1E 26 25 2E 36 3D 3E 46 and give 48..57; shift is ignored.
  - 29=32 (space), 5A=128, 66=129, 76=140.
- Code map, extended (E0 prefix): 6B=130, 75=131, 74=132, 72=133, 6C=134, 69=135, 7D=136, 7A=137, 70=138, 71=139.
- key_code upper bits are always 0 (codes fit in 8 bits, zero-extended).
- Reset mid-frame: state is lost; the next valid start bit begins a fresh frame. The receiver never transmits (host-to-device is unsupported), so ps2_clk/ps2_data are inputs only.

Test Plan:
- Frame 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1) at a 12.5 kHz PS/2 clock -> scan_valid pulse, scan_code=0x1C; key_code=97 one cycle later. Then F0 1C -> key_code=0.
- Sequence 12, 1C, F0 1C, F0 12 -> key_code 65, then 0; shift is clear afterwards. Re-sending 1C -> key_code 97.
- Sequence E0 75, then E0 F0 75 -> key_code 131, then 0. Non-extended 75 alone -> no change (unmapped).
- Make 1C, make 32, break 1C -> key_code 97, then 98, stays 98. Break 32 -> 0.
- 0x1C frame with parity forced to 1 -> parity_err pulse, no scan_valid, key_code unchanged. Frame with stop=0 -> frame_err only.
- Stop ps2_clk after 4 data bits for TIMEOUT_CYCLES+10 cycles -> frame_err pulse, FSM in IDLE; next full 0x29 frame gives key_code=32. A reset pulse mid-frame -> all outputs 0 on the following cycle.

Source files
------------

// File: rtl/ps2_keyboard.sv
// rtl/ps2_keyboard.sv - PS/2 set-2 keyboard receiver and Hack key-code decoder.
module ps2_keyboard #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int DATA_WIDTH     = 16
) (
  input  logic                  CLK_50,
  input  logic                  reset,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  output logic [DATA_WIDTH-1:0] key_code,
  output logic [7:0]            scan_code,
  output logic                  scan_valid,
  output logic                  parity_err,
  output logic                  frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]    clk_sync, data_sync;
  logic          clk_filt, data_filt, clk_prev, fall;
  logic [FW-1:0] clk_cnt, data_cnt;
  state_t        state, state_next;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] wd_cnt;
  logic          timeout, rx_ok, rx_par, rx_frm;
  logic          ext_flag, brk_flag, shift;
  logic [8:0]    held_scan, mapped;

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_filt;
    end
  end

  // A level is accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      clk_filt <= 1'b1;
      clk_cnt  <= '0;
    end else if (clk_sync[1] == clk_filt) begin
      clk_cnt <= '0;
    end else if (clk_cnt == FW'(FILTER_LEN - 1)) begin
      clk_filt <= clk_sync[1];
      clk_cnt  <= '0;
    end else begin
      clk_cnt <= clk_cnt + FW'(1);
    end
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      data_filt <= 1'b1;
      data_cnt  <= '0;
    end else if (data_sync[1] == data_filt) begin
      data_cnt <= '0;
    end else if (data_cnt == FW'(FILTER_LEN - 1)) begin
      data_filt <= data_sync[1];
      data_cnt  <= '0;
    end else begin
      data_cnt <= data_cnt + FW'(1);
    end
  end

  assign fall    = clk_prev & ~clk_filt;
  assign timeout = (state != S_IDLE) && !fall && (wd_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge CLK_50) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    rx_ok      = 1'b0;
    rx_par     = 1'b0;
    rx_frm     = 1'b0;
    if (timeout) begin
      state_next = S_IDLE;
      rx_frm     = 1'b1;
    end else if (fall) begin
      case (state)
        S_IDLE:   if (!data_filt) state_next = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) state_next = S_PARITY;
        S_PARITY: state_next = S_STOP;
        S_STOP: begin
          state_next = S_IDLE;
          if (!data_filt)             rx_frm = 1'b1;
          else if (^{shreg, par_bit}) rx_ok  = 1'b1;
          else                        rx_par = 1'b1;
        end
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      wd_cnt     <= '0;
      scan_code  <= '0;
      scan_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      scan_valid <= rx_ok;
      parity_err <= rx_par;
      frame_err  <= rx_frm;
      if (rx_ok) scan_code <= shreg;
      if (state == S_IDLE || fall)         wd_cnt <= '0;
      else if (wd_cnt != TW'(TIMEOUT_CYCLES)) wd_cnt <= wd_cnt + TW'(1);
      if (fall) begin
        case (state)
          S_IDLE:   bit_cnt <= '0;
          S_DATA: begin
            shreg   <= {data_filt, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          S_PARITY: par_bit <= data_filt;
          default:  ;
        endcase
      end
    end
  end

  // Returns {mapped, code}; letters depend on the shift state at make time.
  function automatic logic [8:0] map_key(input logic ext, input logic [7:0] sc, input logic sh);
    logic [8:0] r;
    logic [4:0] idx;
    logic       is_letter;
    r         = '0;
    idx       = '0;
    is_letter = 1'b1;
    if (ext) begin
      is_letter = 1'b0;
      case (sc)
        8'h6B: r = {1'b1, 8'd130};  8'h75: r = {1'b1, 8'd131};
        8'h74: r = {1'b1, 8'd132};  8'h72: r = {1'b1, 8'd133};
        8'h6C: r = {1'b1, 8'd134};  8'h69: r = {1'b1, 8'd135};
        8'h7D: r = {1'b1, 8'd136};  8'h7A: r = {1'b1, 8'd137};
        8'h70: r = {1'b1, 8'd138};  8'h71: r = {1'b1, 8'd139};
        default: r = '0;
      endcase
    end else begin
      case (sc)
        8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;   8'h23: idx = 5'd3;
        8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;   8'h34: idx = 5'd6;   8'h33: idx = 5'd7;
        8'h43: idx = 5'd8;   8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
        8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;  8'h4D: idx = 5'd15;
        8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;  8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;
        8'h3C: idx = 5'd20;  8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
        8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
        default: is_letter = 1'b0;
      endcase
      if (is_letter) begin
        r = {1'b1, (sh ? 8'd65 : 8'd97) + {3'b000, idx}};
      end else begin
        case (sc)
          8'h45: r = {1'b1, 8'd48};  8'h16: r = {1'b1, 8'd49};
          8'h1E: r = {1'b1, 8'd50};  8'h26: r = {1'b1, 8'd51};
          8'h25: r = {1'b1, 8'd52};  8'h2E: r = {1'b1, 8'd53};
          8'h36: r = {1'b1, 8'd54};  8'h3D: r = {1'b1, 8'd55};
          8'h3E: r = {1'b1, 8'd56};  8'h46: r = {1'b1, 8'd57};
          8'h29: r = {1'b1, 8'd32};  8'h5A: r = {1'b1, 8'd128};
          8'h66: r = {1'b1, 8'd129}; 8'h76: r = {1'b1, 8'd140};
          default: r = '0;
        endcase
      end
    end
    return r;
  endfunction

  assign mapped = map_key(ext_flag, scan_code, shift);

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
      shift     <= 1'b0;
      held_scan <= '0;
      key_code  <= '0;
    end else if (scan_valid) begin
      if (scan_code == 8'hE0) begin
        ext_flag <= 1'b1;
      end else if (scan_code == 8'hF0) begin
        brk_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
        if (!ext_flag && (scan_code == 8'h12 || scan_code == 8'h59)) begin
          shift <= !brk_flag;
        end else if (brk_flag) begin
          if ({ext_flag, scan_code} == held_scan) begin
            key_code  <= '0;
            held_scan <= '0;
          end
        end else if (mapped[8]) begin
          key_code  <= DATA_WIDTH'(mapped[7:0]);
          held_scan <= {ext_flag, scan_code};
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb/tb_ps2_keyboard.sv - scoreboard bench for ps2_keyboard with a key-level reference model.
module tb_ps2_keyboard;

  localparam int TMO = 200;
  localparam int HP  = 16;

  logic        CLK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] key_code;
  logic [7:0]  scan_code;
  logic        scan_valid, parity_err, frame_err;

  int total = 0;
  int passed = 0;

  typedef struct {int kind; int val;} ev_t;  // kind: 0 scan, 1 parity_err, 2 frame_err, 3 key
  ev_t expq[$];

  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] misc_sc [4]  = '{8'h29, 8'h5A, 8'h66, 8'h76};
  int         misc_cd [4]  = '{32, 128, 129, 140};
  logic [7:0] ext_sc [10]  = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71};

  bit m_ext, m_brk, m_shift;
  int m_held, m_key;
  int last_key;
  bit sv_prev;

  ps2_keyboard #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO), .DATA_WIDTH(16)) dut (
    .CLK_50(CLK_50), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_code(key_code), .scan_code(scan_code), .scan_valid(scan_valid),
    .parity_err(parity_err), .frame_err(frame_err)
  );

  always #10 CLK_50 = ~CLK_50;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int ref_code(input bit ext, input logic [7:0] b, input bit sh);
    if (ext) begin
      foreach (ext_sc[i]) if (ext_sc[i] == b) return 130 + i;
      return -1;
    end
    foreach (letters[i]) if (letters[i] == b) return (sh ? 65 : 97) + i;
    foreach (digits[i])  if (digits[i] == b)  return 48 + i;
    foreach (misc_sc[i]) if (misc_sc[i] == b) return misc_cd[i];
    return -1;
  endfunction

  task automatic push_ev(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    expq.push_back(e);
  endtask

  task automatic set_key(input int v);
    if (v != m_key) push_ev(3, v);
    m_key = v;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int c;
    int id;
    push_ev(0, int'(b));
    id = (m_ext ? 256 : 0) + int'(b);
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (!m_ext && (b == 8'h12 || b == 8'h59)) m_shift = !m_brk;
      else if (m_brk) begin
        if (id == m_held) begin
          set_key(0);
          m_held = -1;
        end
      end else begin
        c = ref_code(m_ext, b, m_shift);
        if (c >= 0) begin
          set_key(c);
          m_held = id;
        end
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop, input int nbits);
    logic [10:0] bits;
    bits = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (HP) @(negedge CLK_50);
      ps2_clk = 1'b0;
      repeat (HP) @(negedge CLK_50);
      ps2_clk = 1'b1;
    end
    repeat (HP) @(negedge CLK_50);
    ps2_data = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(negedge CLK_50);
      n++;
    end
    if (expq.size() != 0) begin
      check("drain_timeout_pending", expq.size(), 0);
      expq.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    send_frame(b, 1'b0, 1'b1, 11);
    drain();
  endtask

  task automatic key_seq(input bit ext, input bit brk, input logic [7:0] b);
    if (ext) send_byte(8'hE0);
    if (brk) send_byte(8'hF0);
    send_byte(b);
  endtask

  task automatic expect_ev(input int kind, input int val);
    ev_t e;
    if (expq.size() == 0) begin
      check("unexpected_event(kind*1000+value)", kind * 1000 + val, -1);
    end else begin
      e = expq.pop_front();
      check("event(kind*1000+value)", kind * 1000 + val, e.kind * 1000 + e.val);
    end
  endtask

  always @(negedge CLK_50) begin
    if (reset) begin
      last_key = 0;
      sv_prev  = 0;
    end else begin
      if (scan_valid) expect_ev(0, int'(scan_code));
      if (parity_err) expect_ev(1, 0);
      if (frame_err)  expect_ev(2, 0);
      if (int'(key_code) != last_key) begin
        expect_ev(3, int'(key_code));
        check("key_one_cycle_after_scan_valid", int'(sv_prev), 1);
      end
      sv_prev  = scan_valid;
      last_key = int'(key_code);
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_key_code"},   int'(key_code), 0);
    check({tag, "_scan_code"},  int'(scan_code), 0);
    check({tag, "_scan_valid"}, int'(scan_valid), 0);
    check({tag, "_parity_err"}, int'(parity_err), 0);
    check({tag, "_frame_err"},  int'(frame_err), 0);
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_shift = 0; m_held = -1; m_key = 0;
    expq.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int r, i;
    bit lm_ext;
    logic [7:0] lm_sc, sc;
    lm_ext = 0;
    lm_sc  = 8'h1C;
    model_reset();
    reset = 1'b1;
    repeat (3) @(negedge CLK_50);
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (4) @(negedge CLK_50);

    key_seq(0, 0, 8'h1C);
    key_seq(0, 1, 8'h1C);
    key_seq(0, 0, 8'h12);
    key_seq(0, 0, 8'h1C);
    key_seq(0, 1, 8'h1C);
    key_seq(0, 1, 8'h12);
    key_seq(0, 0, 8'h1C);
    key_seq(0, 1, 8'h1C);
    key_seq(1, 0, 8'h75);
    key_seq(1, 1, 8'h75);
    key_seq(0, 0, 8'h75);
    key_seq(0, 0, 8'h1C);
    key_seq(0, 0, 8'h32);
    key_seq(0, 1, 8'h1C);
    key_seq(0, 1, 8'h32);

    push_ev(1, 0);
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    drain();
    push_ev(2, 0);
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    drain();

    push_ev(2, 0);
    send_frame(8'h1C, 1'b0, 1'b1, 5);
    repeat (TMO + 10) @(negedge CLK_50);
    drain();
    key_seq(0, 0, 8'h29);

    send_frame(8'h1C, 1'b0, 1'b1, 6);
    reset = 1'b1;
    @(posedge CLK_50);
    #1;
    check_outputs_zero("midframe_reset");
    model_reset();
    @(negedge CLK_50);
    reset = 1'b0;
    repeat (4) @(negedge CLK_50);
    key_seq(0, 0, 8'h1C);

    for (int it = 0; it < 20; it++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: key_seq(lm_ext, 1, lm_sc);
        1: key_seq(0, $urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? 8'h12 : 8'h59);
        2: begin
          i = $urandom_range(0, 9);
          sc = ext_sc[i];
          key_seq(1, 0, sc);
          lm_ext = 1;
          lm_sc = sc;
        end
        default: begin
          i = $urandom_range(0, 41);
          if (i < 26)      sc = letters[i];
          else if (i < 36) sc = digits[i - 26];
          else if (i < 40) sc = misc_sc[i - 36];
          else             sc = (i == 40) ? 8'h0E : 8'h75;
          key_seq(0, 0, sc);
          lm_ext = 0;
          lm_sc = sc;
        end
      endcase
    end

    drain();
    check("final_queue_empty", expq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
